rx_codeword_framer: RTL
=======================

# rx_codeword_framer

Upstream framing stage for the (20,A) block-code decoder. Collects the serial stream of DATA_WIDTH-bit soft symbols into complete 20-symbol codewords using a two-bank ping-pong buffer. Presents each codeword in parallel, together with its latched information length, to the decoder through a valid/ready handshake. Reports codewords dropped because both banks are occupied.

## Interface
- DATA_WIDTH, 4: soft-symbol width, two's complement, passed through unmodified.
- CW_LEN, 20: symbols per codeword.
- clk, input, 1: single clock, rising edge.
- rst, input, 1: asynchronous, active-low reset.
- flush, input, 1: synchronous clear of the partial codeword and both banks. Does not clear drop_cnt.
- rx_symbols, input, DATA_WIDTH: soft symbol.
- rx_symbols_valid, input, 1: rx_symbols is valid this cycle. There is no back-pressure, so every valid symbol is consumed or dropped.
- code_length, input, 4: information bits A. Sampled on the first symbol of each codeword.
- cw_symbols, output, CW_LEN*DATA_WIDTH: symbol k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]. Symbol 0 is the first received.
- cw_code_length, output, 4: A latched for the presented codeword.
- cw_valid, output, 1: a complete codeword is presented.
- cw_ready, input, 1: decoder accepts the codeword.
- overflow, output, 1: sticky. Set on any drop. Cleared only by rst or flush.
- drop_cnt, output, 8: dropped codewords. Saturates at 255 and is cleared only by rst.

## Operation
- Banks: B0 and B1. Each holds CW_LEN symbols, a 4-bit length and a full flag.
- Write side has pointer wr_pos (0..CW_LEN-1), wr_bank and a write state machine:
  - IDLE: waiting for the first symbol of a codeword (wr_pos=0).
    - On a valid symbol with target bank not full (a release in the same cycle counts as not full): store the symbol at position 0, latch the clamped code_length, wr_pos=1, go to FILL.
    - On a valid symbol with target bank full: go to DROP, wr_pos=1, set overflow, increment drop_cnt.
  - FILL: each valid symbol is stored at wr_pos and wr_pos increments.
    - On the symbol at CW_LEN-1: set the bank's full flag, toggle wr_bank, wr_pos=0, go to IDLE.
  - DROP: count CW_LEN-1 further valid symbols without storing them, then return to IDLE. wr_bank is unchanged.
- Gaps (rx_symbols_valid=0) in any state hold all write state.
- code_length clamping: values above 13 latch as 13, 0 latches as 1, and 1..13 latch unchanged.
- Read side:
  - rd_bank starts at B0.
  - cw_valid is the full flag of rd_bank.
  - cw_symbols and cw_code_length mux rd_bank's storage directly and are stable while cw_valid=1.
  - Transfer occurs when cw_valid and cw_ready are both 1. On that edge, clear the full flag and toggle rd_bank.
- Codewords leave in arrival order. A dropped codeword never reaches the output.
- flush: wr_pos=0, write state IDLE, both full flags cleared, wr_bank=rd_bank=B0, overflow=0. Flush takes priority over a same-cycle symbol or transfer; that symbol is discarded.

## Timing
- Reset values:
  - cw_valid=0, cw_symbols=0, cw_code_length=0.
  - overflow=0, drop_cnt=0.
  - Write state IDLE, wr_pos=0, both banks empty, rd_bank=wr_bank=B0.
- Latency: cw_valid rises on the clock edge that stores symbol CW_LEN-1. It is visible in the cycle after that symbol is presented.
- A codeword is held until cw_ready arrives, with no timeout. cw_ready while cw_valid=0 has no effect.
- Back-to-back transfers: the other bank, if full, is presented in the cycle right after a transfer.
- Sustained throughput is one codeword per CW_LEN cycles, with no drops, provided cw_ready is asserted within CW_LEN cycles of cw_valid.
- Release bypass: a release and the first symbol of a new codeword into that same bank in one cycle is legal and does not count as a drop.
- Reset mid-codeword discards the partial codeword. Reset mid-presentation deasserts cw_valid immediately (asynchronously).

## Test plan
- Continuous stream, symbols 0..19 as values 0,1,..,15,0,1,2,3 (mod 16), code_length=13, cw_ready=1: one cw_valid pulse one cycle after the 20th symbol. Symbol 19 (value 3) is at bits [79:76]. cw_code_length=13.
- 60 back-to-back symbols with cw_ready=0 throughout: two codewords buffered, the third dropped, overflow=1, drop_cnt=1. Then raise cw_ready: codewords 1 and 2 appear on consecutive cycles, codeword 3 never appears.
- Random gaps in rx_symbols_valid (about 50% duty) with cw_ready=1: output contents are identical to the gap-free run and nothing is dropped.
- code_length=15 for the first codeword and 0 for the second: cw_code_length reads 13 then 1. Changing code_length mid-codeword has no effect.
- Assert cw_ready exactly on the cycle the next codeword's first symbol targets the bank being released: no overflow, and contents are correct.
- Assert rst (low) at symbol 10, then send 20 clean symbols: only the clean codeword is output, with drop_cnt=0. Assert flush with B0 full and B1 filling: cw_valid=0 next cycle and overflow=0.

Source files
------------

// File: rtl/rx_codeword_framer.sv
// Collects a serial stream of soft symbols into CW_LEN-symbol codewords.
// Two ping-pong banks feed the decoder through a valid/ready handshake.
module rx_codeword_framer #(
    parameter int DATA_WIDTH = 4,
    parameter int CW_LEN     = 20
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic [DATA_WIDTH-1:0]        rx_symbols,
    input  logic                         rx_symbols_valid,
    input  logic [3:0]                   code_length,
    output logic [CW_LEN*DATA_WIDTH-1:0] cw_symbols,
    output logic [3:0]                   cw_code_length,
    output logic                         cw_valid,
    input  logic                         cw_ready,
    output logic                         overflow,
    output logic [7:0]                   drop_cnt
);

    localparam int POS_W = $clog2(CW_LEN);
    localparam int CW_W  = CW_LEN * DATA_WIDTH;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_FILL,
        WR_DROP
    } wr_state_t;

    wr_state_t        wr_state_reg;
    logic [POS_W-1:0] wr_pos_reg;
    logic             wr_bank_reg;
    logic             rd_bank_reg;
    logic             overflow_reg;
    logic [7:0]       drop_cnt_reg;

    logic [1:0]       full_vec;
    logic [CW_W-1:0]  bank_data [2];
    logic [3:0]       bank_len  [2];

    logic             xfer;
    logic             tgt_busy;
    logic             wr_last;
    logic             sym_we;
    logic [3:0]       len_clamped;
    logic [1:0]       full_set;
    logic [1:0]       full_clr;

    // A release of the bank being targeted frees it in the same cycle.
    always_comb begin
        xfer        = full_vec[rd_bank_reg] & cw_ready;
        tgt_busy    = full_vec[wr_bank_reg] & ~(xfer & (rd_bank_reg == wr_bank_reg));
        wr_last     = (wr_pos_reg == POS_W'(CW_LEN - 1));
        sym_we      = rx_symbols_valid & ~flush &
                      (((wr_state_reg == WR_IDLE) & ~tgt_busy) | (wr_state_reg == WR_FILL));
        len_clamped = code_length;
        if (code_length > 4'd13)
            len_clamped = 4'd13;
        else if (code_length == 4'd0)
            len_clamped = 4'd1;
        full_set = '0;
        full_clr = '0;
        full_set[wr_bank_reg] = sym_we & (wr_state_reg == WR_FILL) & wr_last;
        full_clr[rd_bank_reg] = xfer;
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : bank_g
            logic [CW_W-1:0] data_reg;
            logic [3:0]      len_reg;
            logic            full_reg;
            logic            sel;

            assign sel = sym_we & (wr_bank_reg == 1'(gi));

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    data_reg <= '0;
                    len_reg  <= '0;
                    full_reg <= 1'b0;
                end else if (flush) begin
                    full_reg <= 1'b0;
                end else begin
                    if (full_clr[gi])
                        full_reg <= 1'b0;
                    if (full_set[gi])
                        full_reg <= 1'b1;
                    if (sel)
                        data_reg[wr_pos_reg*DATA_WIDTH +: DATA_WIDTH] <= rx_symbols;
                    if (sel && wr_state_reg == WR_IDLE)
                        len_reg <= len_clamped;
                end
            end

            assign full_vec[gi]  = full_reg;
            assign bank_data[gi] = data_reg;
            assign bank_len[gi]  = len_reg;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_state_reg <= WR_IDLE;
            wr_pos_reg   <= '0;
            wr_bank_reg  <= 1'b0;
            rd_bank_reg  <= 1'b0;
            overflow_reg <= 1'b0;
            drop_cnt_reg <= '0;
        end else if (flush) begin
            wr_state_reg <= WR_IDLE;
            wr_pos_reg   <= '0;
            wr_bank_reg  <= 1'b0;
            rd_bank_reg  <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            if (xfer)
                rd_bank_reg <= ~rd_bank_reg;
            if (rx_symbols_valid) begin
                case (wr_state_reg)
                    WR_IDLE: begin
                        wr_pos_reg <= POS_W'(1);
                        if (tgt_busy) begin
                            wr_state_reg <= WR_DROP;
                            overflow_reg <= 1'b1;
                            if (drop_cnt_reg != 8'd255)
                                drop_cnt_reg <= drop_cnt_reg + 8'd1;
                        end else begin
                            wr_state_reg <= WR_FILL;
                        end
                    end
                    WR_FILL: begin
                        if (wr_last) begin
                            wr_pos_reg   <= '0;
                            wr_bank_reg  <= ~wr_bank_reg;
                            wr_state_reg <= WR_IDLE;
                        end else begin
                            wr_pos_reg <= wr_pos_reg + 1'b1;
                        end
                    end
                    WR_DROP: begin
                        // Dropped codewords leave wr_bank where it was.
                        if (wr_last) begin
                            wr_pos_reg   <= '0;
                            wr_state_reg <= WR_IDLE;
                        end else begin
                            wr_pos_reg <= wr_pos_reg + 1'b1;
                        end
                    end
                    default: begin
                        wr_pos_reg   <= '0;
                        wr_state_reg <= WR_IDLE;
                    end
                endcase
            end
        end
    end

    assign cw_valid       = full_vec[rd_bank_reg];
    assign cw_symbols     = bank_data[rd_bank_reg];
    assign cw_code_length = bank_len[rd_bank_reg];
    assign overflow       = overflow_reg;
    assign drop_cnt       = drop_cnt_reg;

endmodule
